// File: rtl/pipe_adder.sv
// pipe_adder: pipelined carry-segmented adder/subtractor, one SEG-bit slice per stage.
// Bubble-collapsing valid/ready pipeline; results are driven from the last-stage registers.
module pipe_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);
  localparam int STAGES = WIDTH / SEG;

  if ((WIDTH % SEG) != 0) begin : g_bad_seg
    $error("pipe_adder: WIDTH must be a multiple of SEG");
  end

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] c_d;

  logic [STAGES-1:0] load_s;
  logic [WIDTH-1:0]  fa_s   [STAGES];
  logic [WIDTH-1:0]  fb_s   [STAGES];
  logic [WIDTH-1:0]  fsum_s [STAGES];
  logic [STAGES-1:0] fc_s;
  logic [STAGES-1:0] fv_s;
  logic [SEG:0]      slice_s [STAGES];

  // Ready chain: stage k may load unless it and every later stage is full and the output stalls.
  always_comb begin
    load_s = '0;
    for (int k = 0; k < STAGES; k++) begin
      load_s[k] = out_ready || !(&(v_q | ({STAGES{1'b1}} >> (STAGES - k))));
    end
  end

  // Stage inputs: operand prep for stage 0, previous stage register for the rest.
  always_comb begin
    fa_s[0]   = a;
    fb_s[0]   = sub ? ~b : b;
    fsum_s[0] = '0;
    fc_s      = '0;
    fv_s      = '0;
    fc_s[0]   = sub ? ~ci : ci;
    fv_s[0]   = in_valid && load_s[0];
    for (int k = 1; k < STAGES; k++) begin
      fa_s[k]   = a_q[k-1];
      fb_s[k]   = b_q[k-1];
      fsum_s[k] = sum_q[k-1];
      fc_s[k]   = c_q[k-1];
      fv_s[k]   = v_q[k-1];
    end
  end

  // Per-stage slice add; a stage whose load is low keeps everything it holds.
  always_comb begin
    v_d = v_q;
    c_d = c_q;
    for (int k = 0; k < STAGES; k++) begin
      slice_s[k] = {1'b0, fa_s[k][k*SEG +: SEG]} + {1'b0, fb_s[k][k*SEG +: SEG]}
                 + {{SEG{1'b0}}, fc_s[k]};
      if (load_s[k]) begin
        a_d[k]                  = fa_s[k];
        b_d[k]                  = fb_s[k];
        sum_d[k]                = fsum_s[k];
        sum_d[k][k*SEG +: SEG]  = slice_s[k][SEG-1:0];
        c_d[k]                  = slice_s[k][SEG];
        v_d[k]                  = fv_s[k];
      end else begin
        a_d[k]   = a_q[k];
        b_d[k]   = b_q[k];
        sum_d[k] = sum_q[k];
        c_d[k]   = c_q[k];
        v_d[k]   = v_q[k];
      end
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      c_q <= c_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

  assign in_ready  = load_s[0];
  assign out_valid = v_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign co        = c_q[STAGES-1];
  // Overflow from the carried operand MSBs (B already inverted for subtract).
  assign ovf       = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1])
                  && (sum_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
endmodule
